adc_capture_asic: RTL and testbench
===================================

// Module: adc_capture_asic
// PURPOSE
//  Core of the ADC-capture chip. On a capture command it emits a burst of
//  fixed-length packets of 18-bit ADC samples with a valid strobe toward the
//  ADC_DATA/ADC_DATA_VALID pads. Samples come from the ADC input or, in
//  self-test mode, from an internal incrementing pattern. Config is driven by
//  the top regfile (MDIO/regfile lives outside this block).
// PARAMETERS
//  DW        18  sample width
//  GAP_W     8   width of pkt_gap
//  IDLE_W    8   width of pkt_idle_len
// PORTS
//  clk            in   1       single core clock; every flop on its rising edge
//  rst            in   1       reset: synchronous, active-high (pad RSTN inverted/synced upstream)
//  clk_en         in   1       pktctrl clock enable; 0 freezes all engine state
//  sw_rstn        in   1       soft reset, active-low, synchronous, same effect as rst
//  self_test_mode in   1       1: internal pattern; 0: adc_din
//  capture_start  in   1       capture command (level; rising edge acts)
//  capture_again  in   1       re-capture command (level; rising edge acts)
//  pkt_gap        in   GAP_W   packets per burst (0 treated as 1)
//  pkt_data_len   in   2       00=216, 01=432, 10=864, 11=1728 words/packet
//  pkt_idle_len   in   IDLE_W  idle cycles between packets (0 = back-to-back)
//  adc_din        in   DW      live ADC sample, sampled each data beat
//  adc_data       out  DW      sample out (registered)
//  adc_data_valid out  1       high on each data beat
//  adc_sop/adc_eop out 1       first/last beat of a packet, qualified by valid
//  busy           out  1       high from first beat to end of last packet
//  done           out  1       1-cycle pulse after the last beat of a burst
// BEHAVIOUR
//  - Reset (rst=1 or sw_rstn=0): state IDLE, all outputs 0, pattern=0, edge regs=0.
//  - clk_en=0: hold all state and outputs (rst/sw_rstn still act).
//  - Edge detect: start_re = capture_start & ~start_q (same for again); regs update when clk_en=1.
//  - FSM IDLE -> DATA -> (IDLE_GAP -> DATA)* -> IDLE.
//  - IDLE: start_re loads pattern=0, pkt_cnt=0, word_cnt=0 -> DATA.
//    again_re keeps pattern value (continues count) -> DATA. Both same cycle: start wins.
//  - Commands in DATA/IDLE_GAP are ignored (no restart, no queueing).
//  - Latency: first adc_data_valid is the cycle after the edge is seen in IDLE.
//  - DATA: one word per cycle; valid=1, sop on word 0, eop on word N-1 (N from pkt_data_len).
//    pattern increments after each self-test beat (18-bit wrap 3FFFF->0).
//    Live mode: adc_data = adc_din registered on the beat.
//  - After eop: if pkt_cnt+1 < max(pkt_gap,1) and pkt_idle_len>0 -> IDLE_GAP for
//    pkt_idle_len cycles (valid=0, data holds last value) -> DATA. Idle_len=0 -> DATA directly.
//    Last packet -> IDLE; done pulses the cycle after the final eop; busy drops same cycle.
//  - Config sampled at burst start; changes mid-burst take effect at the next burst.
//  - Reset mid-burst aborts immediately: valid=0, busy=0, no done pulse.
//  - Burst length = gap*N + (gap-1)*idle_len cycles.
// TESTING
//  1 Self-test, start pulse, len=01, gap=8, idle=15 -> 8 packets x 432 beats, 15 idle
//    cycles between, 3561 cycles busy, data 0..3455 (0xD7F), done once.
//  2 Len=00/10/11, gap=1, idle=0 -> exactly 216/864/1728 beats, sop/eop at ends.
//  3 After test 1, again pulse -> new burst starts at 0xD80; start pulse -> starts at 0.
//  4 Start pulse while busy -> ignored, burst unchanged; gap=0 -> one packet.
//  5 clk_en=0 for 10 cycles mid-packet -> outputs freeze, resume without lost/duplicate word.
//  6 rst or sw_rstn=0 mid-burst -> next cycle valid=0, busy=0, no done; live mode
//    adc_din ramp echoed one cycle later.

Source files
------------

// File: rtl/adc_capture_asic.sv
// adc_capture_asic
//   Packet engine of the ADC-capture chip. A capture command produces a burst
//   of fixed-length packets of DW-bit samples, taken either from the live ADC
//   input or from an internal incrementing self-test pattern.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   clk_en               engine clock enable (0 freezes all state and outputs)
//   sw_rstn              synchronous active-low soft reset, same effect as rst
//   self_test_mode       1: internal pattern, 0: adc_din
//   capture_start/again  level commands, rising edge acts (start restarts
//                        the pattern at 0, again continues it)
//   pkt_gap              packets per burst (0 behaves as 1)
//   pkt_data_len         00=216, 01=432, 10=864, 11=1728 words per packet
//   pkt_idle_len         idle cycles between packets
//   adc_din              live sample input
//   adc_data/_valid      registered sample and its beat strobe
//   adc_sop/adc_eop      first/last beat of a packet, qualified by valid
//   busy, done           burst in progress / one-cycle end-of-burst pulse
//   state_dbg            current FSM state
//
// Handshake: adc_data_valid is a pure strobe; there is no ready and no
// backpressure, and the sink must take every beat on which valid is high.
module adc_capture_asic #(
  parameter int DW     = 18,
  parameter int GAP_W  = 8,
  parameter int IDLE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              sw_rstn,
  input  logic              self_test_mode,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic [GAP_W-1:0]  pkt_gap,
  input  logic [1:0]        pkt_data_len,
  input  logic [IDLE_W-1:0] pkt_idle_len,
  input  logic [DW-1:0]     adc_din,
  output logic [DW-1:0]     adc_data,
  output logic              adc_data_valid,
  output logic              adc_sop,
  output logic              adc_eop,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d, again_q, again_d;
  logic [DW-1:0]     pat_q, pat_d;
  logic [GAP_W-1:0]  pkt_q, pkt_d;
  logic [10:0]       word_q, word_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [GAP_W-1:0]  gap_cfg_q, gap_cfg_d;
  logic [1:0]        len_cfg_q, len_cfg_d;
  logic [IDLE_W-1:0] idle_cfg_q, idle_cfg_d;
  logic              st_cfg_q, st_cfg_d;
  logic [DW-1:0]     data_q, data_d;
  logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              start_re, again_re;
  logic              emit;
  logic [DW-1:0]     emit_pat;
  logic [10:0]       emit_word;
  logic [GAP_W-1:0]  gap_eff;
  logic [GAP_W:0]    pkt_next;
  logic              more_pkts;

  function automatic logic [10:0] last_idx(input logic [1:0] len);
    case (len)
      2'b00:   last_idx = 11'd215;
      2'b01:   last_idx = 11'd431;
      2'b10:   last_idx = 11'd863;
      default: last_idx = 11'd1727;
    endcase
  endfunction

  always_comb begin
    start_re  = capture_start & ~start_q;
    again_re  = capture_again & ~again_q;
    gap_eff   = (gap_cfg_q == '0) ? {{(GAP_W-1){1'b0}}, 1'b1} : gap_cfg_q;
    pkt_next  = {1'b0, pkt_q} + {{GAP_W{1'b0}}, 1'b1};
    more_pkts = pkt_next < {1'b0, gap_eff};

    state_d    = state_q;
    start_d    = capture_start;
    again_d    = capture_again;
    pat_d      = pat_q;
    pkt_d      = pkt_q;
    word_d     = word_q;
    idle_d     = idle_q;
    gap_cfg_d  = gap_cfg_q;
    len_cfg_d  = len_cfg_q;
    idle_cfg_d = idle_cfg_q;
    st_cfg_d   = st_cfg_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    done_d     = 1'b0;
    emit       = 1'b0;
    emit_pat   = pat_q;
    emit_word  = '0;

    case (state_q)
      S_IDLE: begin
        // Start wins over again; config is captured only here so that
        // mid-burst changes wait for the next burst.
        if (start_re || again_re) begin
          gap_cfg_d  = pkt_gap;
          len_cfg_d  = pkt_data_len;
          idle_cfg_d = pkt_idle_len;
          st_cfg_d   = self_test_mode;
          pkt_d      = '0;
          emit       = 1'b1;
          emit_pat   = start_re ? '0 : pat_q;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (word_q != last_idx(len_cfg_q)) begin
          emit      = 1'b1;
          emit_word = word_q + 11'd1;
        end else if (more_pkts) begin
          pkt_d = pkt_next[GAP_W-1:0];
          if (idle_cfg_q != '0) begin
            // The cycle spent entering S_GAP is the first idle cycle.
            state_d = S_GAP;
            idle_d  = idle_cfg_q - {{(IDLE_W-1){1'b0}}, 1'b1};
          end else begin
            emit = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (idle_q == '0) begin
          emit    = 1'b1;
          state_d = S_DATA;
        end else begin
          idle_d = idle_q - {{(IDLE_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers carry the beat chosen this cycle, so the first beat
    // appears the cycle after the command edge is seen.
    if (emit) begin
      word_d  = emit_word;
      valid_d = 1'b1;
      sop_d   = (emit_word == 11'd0);
      eop_d   = (emit_word == last_idx(len_cfg_d));
      if (st_cfg_d) begin
        data_d = emit_pat;
        pat_d  = emit_pat + DW'(1);
      end else begin
        data_d = adc_din;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || !sw_rstn) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      again_q    <= 1'b0;
      pat_q      <= '0;
      pkt_q      <= '0;
      word_q     <= '0;
      idle_q     <= '0;
      gap_cfg_q  <= '0;
      len_cfg_q  <= '0;
      idle_cfg_q <= '0;
      st_cfg_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      start_q    <= start_d;
      again_q    <= again_d;
      pat_q      <= pat_d;
      pkt_q      <= pkt_d;
      word_q     <= word_d;
      idle_q     <= idle_d;
      gap_cfg_q  <= gap_cfg_d;
      len_cfg_q  <= len_cfg_d;
      idle_cfg_q <= idle_cfg_d;
      st_cfg_q   <= st_cfg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign adc_data       = data_q;
  assign adc_data_valid = valid_q;
  assign adc_sop        = sop_q;
  assign adc_eop        = eop_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_adc_capture_asic.sv
module tb_adc_capture_asic;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic          sw_rstn = 1'b1;
  logic          self_test_mode = 1'b1;
  logic          capture_start = 1'b0;
  logic          capture_again = 1'b0;
  logic [7:0]    pkt_gap = 8'd1;
  logic [1:0]    pkt_data_len = 2'd0;
  logic [7:0]    pkt_idle_len = 8'd0;
  logic [DW-1:0] adc_din = '0;
  logic [DW-1:0] adc_data;
  logic          adc_data_valid, adc_sop, adc_eop, busy, done;
  logic [1:0]    state_dbg;

  adc_capture_asic dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sw_rstn(sw_rstn),
    .self_test_mode(self_test_mode), .capture_start(capture_start),
    .capture_again(capture_again), .pkt_gap(pkt_gap),
    .pkt_data_len(pkt_data_len), .pkt_idle_len(pkt_idle_len),
    .adc_din(adc_din), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
    .adc_sop(adc_sop), .adc_eop(adc_eop), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [DW+1:0] exp_q[$];     // {sop, eop, data}
  logic [DW-1:0] m_pat = '0;
  bit   tb_live = 1'b0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   done_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Values seen by the DUT at the last rising edge.
  logic          en_e = 1'b1, rst_e = 1'b1;
  logic [DW-1:0] din_e = '0;
  always @(posedge clk) begin
    en_e  <= clk_en;
    rst_e <= rst | ~sw_rstn;
    din_e <= adc_din;
  end

  logic [DW-1:0] p_data = '0;
  logic [4:0]    p_ctl = '0;
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (rst_e) begin
      check("abort_valid", {31'd0, adc_data_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
    end else if (!en_e) begin
      check("freeze_data", {14'd0, adc_data}, {14'd0, p_data});
      check("freeze_ctl", {27'd0, adc_data_valid, adc_sop, adc_eop, busy, done}, {27'd0, p_ctl});
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (adc_data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sop", {31'd0, adc_sop}, {31'd0, e[DW+1]});
          check("eop", {31'd0, adc_eop}, {31'd0, e[DW]});
          check("data", {14'd0, adc_data}, {14'd0, (tb_live ? din_e : e[DW-1:0])});
        end
      end else begin
        check("stray_flag", {30'd0, adc_sop, adc_eop}, 32'd0);
      end
    end
    p_data = adc_data;
    p_ctl  = {adc_data_valid, adc_sop, adc_eop, busy, done};
  end

  // Live ADC ramp.
  initial begin
    forever begin
      @(posedge clk); #1;
      adc_din = adc_din + 18'd7;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit use_sw);
    @(posedge clk); #1;
    if (use_sw) sw_rstn = 1'b0; else rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sw_rstn = 1'b1;
    exp_q.delete();
    m_pat = '0;
    check("rst_valid", {31'd0, adc_data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
  endtask

  task automatic start_burst(input logic [1:0] len, input logic [7:0] gap,
                             input logic [7:0] idle, input bit st, input bit again);
    int n, g;
    n = 216 << len;
    g = (gap == 0) ? 1 : int'(gap);
    pkt_data_len   = len;
    pkt_gap        = gap;
    pkt_idle_len   = idle;
    self_test_mode = st;
    tb_live        = !st;
    if (!again && st) m_pat = '0;
    for (int p = 0; p < g; p++) begin
      for (int w = 0; w < n; w++) begin
        exp_q.push_back({(w == 0), (w == n - 1), (st ? m_pat : {DW{1'b0}})});
        if (st) m_pat = m_pat + 18'd1;
      end
    end
    busy_cnt  = 0;
    done_base = done_cnt;
    if (again) capture_again = 1'b1; else capture_start = 1'b1;
    @(posedge clk); #1;
    capture_start = 1'b0;
    capture_again = 1'b0;
    check("latency_valid", {31'd0, adc_data_valid}, 32'd1);
    check("latency_sop", {31'd0, adc_sop}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == done_base) check({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_done_count"}, done_cnt - done_base, 32'd1);
    check({tag, "_leftover"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    check("rst_data", {14'd0, adc_data}, 32'd0);

    // 1: 8 packets of 432 with 15 idle cycles between.
    start_burst(2'd1, 8'd8, 8'd15, 1'b1, 1'b0);
    wait_done("t1", 5000);
    check("t1_busy_cycles", busy_cnt, 32'd3561);

    // 3: again continues the pattern at 0xD80, start restarts at 0.
    start_burst(2'd1, 8'd8, 8'd15, 1'b1, 1'b1);
    wait_done("t3a", 5000);
    check("t3a_busy_cycles", busy_cnt, 32'd3561);
    start_burst(2'd0, 8'd1, 8'd0, 1'b1, 1'b0);
    wait_done("t3b", 1000);

    // 2: single packets of each remaining length.
    for (int l = 0; l < 4; l++) begin
      if (l != 1) begin
        start_burst(2'(l), 8'd1, 8'd0, 1'b1, 1'b0);
        wait_done("t2", 3000);
        check("t2_busy_cycles", busy_cnt, 216 << l);
      end
    end

    // 4: gap=0 is one packet; start and config changes while busy are ignored.
    start_burst(2'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    pkt_data_len  = 2'd3;
    pkt_gap       = 8'd5;
    capture_start = 1'b1;
    @(posedge clk); #1;
    capture_start = 1'b0;
    wait_done("t4", 1000);
    check("t4_busy_cycles", busy_cnt, 32'd216);

    // 5: clock-enable freeze mid-packet.
    start_burst(2'd0, 8'd2, 8'd4, 1'b1, 1'b1);
    repeat ($urandom_range(40, 120)) @(posedge clk);
    #1;
    clk_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clk_en = 1'b1;
    wait_done("t5", 1000);
    check("t5_busy_cycles", busy_cnt, 32'd436);

    // 6: reset aborts mid-burst with no done; soft reset in live mode.
    start_burst(2'd0, 8'd2, 8'd3, 1'b1, 1'b0);
    repeat ($urandom_range(30, 150)) @(posedge clk);
    done_base = done_cnt;
    do_reset(1'b0);
    repeat (300) @(posedge clk);
    #1;
    check("t6_no_done_rst", done_cnt - done_base, 32'd0);

    start_burst(2'd0, 8'd3, 8'd2, 1'b0, 1'b0);
    repeat ($urandom_range(50, 400)) @(posedge clk);
    done_base = done_cnt;
    do_reset(1'b1);
    repeat (700) @(posedge clk);
    #1;
    check("t6_no_done_sw", done_cnt - done_base, 32'd0);

    // Live full burst, then pattern restarts from 0 after reset via again.
    start_burst(2'd0, 8'd2, 8'd1, 1'b0, 1'b0);
    wait_done("t6_live", 1000);
    start_burst(2'd0, 8'd1, 8'd0, 1'b1, 1'b1);
    wait_done("t6_pat", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
